// File: rtl/debug_access_gate.sv
// Debug access gate: key-based unlock, lockout after repeated bad keys, idle relock,
// and single-outstanding forwarding of host requests onto the debug register bus.
module debug_access_gate #(
  parameter logic [31:0] UNLOCK_KEY     = 32'hA5C3_5A3C,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 1024,
  parameter int unsigned IDLE_TIMEOUT   = 4096,
  parameter int unsigned DBG_TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_req_valid,
  output logic        host_req_ready,
  input  logic        host_req_write,
  input  logic [7:0]  host_req_addr,
  input  logic [31:0] host_req_wdata,
  output logic        host_rsp_valid,
  output logic [31:0] host_rsp_data,
  output logic        host_rsp_err,
  output logic        debug_enable,
  output logic [7:0]  debug_addr,
  output logic [31:0] debug_data_in,
  input  logic [31:0] debug_data_out,
  input  logic        debug_ready,
  output logic        unlocked,
  output logic        lockout
);

  localparam int unsigned FAIL_W = $clog2(MAX_FAILS + 1);
  localparam int unsigned LOCK_W = $clog2(LOCKOUT_CYCLES + 1);
  localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam int unsigned DBG_W  = $clog2(DBG_TIMEOUT + 1);

  localparam logic [7:0] KEY_ADDR    = 8'hE0;
  localparam logic [7:0] RELOCK_ADDR = 8'hE1;

  typedef enum logic [2:0] {
    S_LOCKED,
    S_UNLOCKED,
    S_ISSUE,
    S_WAIT,
    S_LOCKOUT
  } state_t;

  state_t            state, state_nxt;
  logic [FAIL_W-1:0] fail_cnt, fail_nxt;
  logic [LOCK_W-1:0] lock_cnt, lock_nxt;
  logic [IDLE_W-1:0] idle_cnt, idle_nxt;
  logic [DBG_W-1:0]  dbg_cnt, dbg_nxt;
  logic              req_write, req_write_nxt;

  logic        rsp_valid_nxt;
  logic [31:0] rsp_data_nxt;
  logic        rsp_err_nxt;
  logic        enable_nxt;
  logic [7:0]  addr_nxt;
  logic [31:0] data_in_nxt;
  logic        ready_nxt;
  logic        unlocked_nxt;
  logic        lockout_nxt;

  logic accept_c;
  logic local_addr_c;

  assign accept_c     = host_req_valid && host_req_ready;
  assign local_addr_c = (host_req_addr[7:4] == 4'hE);

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_LOCKED;
      fail_cnt       <= '0;
      lock_cnt       <= '0;
      idle_cnt       <= '0;
      dbg_cnt        <= '0;
      req_write      <= 1'b0;
      host_rsp_valid <= 1'b0;
      host_rsp_data  <= '0;
      host_rsp_err   <= 1'b0;
      debug_enable   <= 1'b0;
      debug_addr     <= '0;
      debug_data_in  <= '0;
      host_req_ready <= 1'b0;
      unlocked       <= 1'b0;
      lockout        <= 1'b0;
    end else begin
      state          <= state_nxt;
      fail_cnt       <= fail_nxt;
      lock_cnt       <= lock_nxt;
      idle_cnt       <= idle_nxt;
      dbg_cnt        <= dbg_nxt;
      req_write      <= req_write_nxt;
      host_rsp_valid <= rsp_valid_nxt;
      host_rsp_data  <= rsp_data_nxt;
      host_rsp_err   <= rsp_err_nxt;
      debug_enable   <= enable_nxt;
      debug_addr     <= addr_nxt;
      debug_data_in  <= data_in_nxt;
      host_req_ready <= ready_nxt;
      unlocked       <= unlocked_nxt;
      lockout        <= lockout_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt     = state;
    fail_nxt      = fail_cnt;
    lock_nxt      = lock_cnt;
    idle_nxt      = idle_cnt;
    dbg_nxt       = dbg_cnt;
    req_write_nxt = req_write;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = '0;
    rsp_err_nxt   = 1'b0;
    enable_nxt    = debug_enable;
    addr_nxt      = debug_addr;
    data_in_nxt   = debug_data_in;

    case (state)
      S_LOCKED: begin
        if (accept_c) begin
          rsp_valid_nxt = 1'b1;
          if (host_req_write && host_req_addr == KEY_ADDR) begin
            if (host_req_wdata == UNLOCK_KEY) begin
              state_nxt = S_UNLOCKED;
              fail_nxt  = '0;
              idle_nxt  = '0;
            end else begin
              rsp_err_nxt = 1'b1;
              if (fail_cnt != FAIL_W'(MAX_FAILS)) begin
                fail_nxt = fail_cnt + 1'b1;
              end
              if (fail_nxt == FAIL_W'(MAX_FAILS)) begin
                state_nxt = S_LOCKOUT;
                lock_nxt  = '0;
              end
            end
          end else begin
            rsp_err_nxt = 1'b1;
          end
        end
      end

      S_UNLOCKED: begin
        if (accept_c) begin
          idle_nxt = '0;
          if (local_addr_c) begin
            rsp_valid_nxt = 1'b1;
            if (host_req_addr == KEY_ADDR) begin
              rsp_err_nxt = 1'b0;
            end else if (host_req_addr == RELOCK_ADDR && host_req_write) begin
              state_nxt = S_LOCKED;
            end else begin
              rsp_err_nxt = 1'b1;
            end
          end else begin
            state_nxt     = S_ISSUE;
            enable_nxt    = 1'b1;
            addr_nxt      = host_req_addr;
            data_in_nxt   = host_req_write ? host_req_wdata : 32'h0;
            req_write_nxt = host_req_write;
            dbg_nxt       = '0;
          end
        end else if (idle_cnt == IDLE_W'(IDLE_TIMEOUT - 1)) begin
          state_nxt = S_LOCKED;
          idle_nxt  = '0;
        end else begin
          idle_nxt = idle_cnt + 1'b1;
        end
      end

      // First enable cycle: a ready seen here may be left over from the previous access
      S_ISSUE: begin
        dbg_nxt   = dbg_cnt + 1'b1;
        state_nxt = S_WAIT;
      end

      S_WAIT: begin
        if (debug_ready) begin
          state_nxt     = S_UNLOCKED;
          enable_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_data_nxt  = req_write ? 32'h0 : debug_data_out;
        end else if (dbg_cnt == DBG_W'(DBG_TIMEOUT - 1)) begin
          state_nxt     = S_UNLOCKED;
          enable_nxt    = 1'b0;
          rsp_valid_nxt = 1'b1;
          rsp_err_nxt   = 1'b1;
        end else begin
          dbg_nxt = dbg_cnt + 1'b1;
        end
      end

      S_LOCKOUT: begin
        if (lock_cnt == LOCK_W'(LOCKOUT_CYCLES - 1)) begin
          state_nxt = S_LOCKED;
          fail_nxt  = '0;
        end else begin
          lock_nxt = lock_cnt + 1'b1;
        end
      end

      default: begin
        state_nxt = S_LOCKED;
      end
    endcase

    ready_nxt    = (state_nxt == S_LOCKED || state_nxt == S_UNLOCKED) && !accept_c;
    unlocked_nxt = (state_nxt == S_UNLOCKED || state_nxt == S_ISSUE || state_nxt == S_WAIT);
    lockout_nxt  = (state_nxt == S_LOCKOUT);
  end

endmodule
